// File: rtl/ext_uart.sv
// ext_uart: 8N1 UART bridge between the core EXT ports and the board serial pins.
// Latency: TX start bit on txd the cycle after cwre; RX byte in cd the cycle after the mid-stop sample.
// Backpressure: cbsy holds off writes for a full frame; an unread byte makes the next one drop and sets rx_ovr.
module ext_uart #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] cd,
  output logic       crda,
  input  logic       cack,
  input  logic [7:0] cq,
  input  logic       cwre,
  output logic       cbsy,
  output logic       rx_ovr,
  output logic       rx_ferr
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  // The falling-edge detect cycle is already the first low sample, so the
  // START counter reaches the bit midpoint one count early.
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

  // ---------------- transmitter ----------------
  st_t           tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shf;
  logic          tx_wrap;

  assign tx_wrap = (tx_cnt == LAST);

  // TX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tx_state <= IDLE;
    else        tx_state <= tx_next;
  end

  // TX next-state: one bit period per state step, eight steps in DATA
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:  if (cwre) tx_next = START;
      START: if (tx_wrap) tx_next = DATA;
      DATA:  if (tx_wrap && tx_idx == 3'd7) tx_next = STOP;
      STOP:  if (tx_wrap) tx_next = IDLE;
      default: tx_next = IDLE;
    endcase
  end

  // TX outputs decode straight from state, so reset forces txd high at once
  always_comb begin
    txd  = 1'b1;
    cbsy = (tx_state != IDLE);
    case (tx_state)
      START:   txd = 1'b0;
      DATA:    txd = tx_shf[0];
      default: txd = 1'b1;
    endcase
  end

  // TX bit timer, bit index and shift register (writes while busy are ignored)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_shf <= '0;
    end else if (tx_state == IDLE) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      if (cwre) tx_shf <= cq;
    end else begin
      tx_cnt <= tx_wrap ? '0 : tx_cnt + 1'b1;
      if (tx_state == DATA && tx_wrap) begin
        tx_shf <= {1'b0, tx_shf[7:1]};
        tx_idx <= tx_idx + 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  st_t           rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shf;
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_mid, stop_ok, stop_bad;

  // Two-flop synchroniser plus previous value for edge detection; idle high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= IDLE;
    else        rx_state <= rx_next;
  end

  // RX next-state: START rejects glitches at the half-bit check
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:  if (rx_prev && !rx_s2) rx_next = START;
      START: if (rx_mid) rx_next = rx_s2 ? IDLE : DATA;
      DATA:  if (rx_mid && rx_idx == 3'd7) rx_next = STOP;
      STOP:  if (rx_mid) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  // RX sample strobes: midpoint of the current bit and the stop-bit verdict
  always_comb begin
    rx_mid   = (rx_state == START) ? (rx_cnt == HALF_M1) : (rx_cnt == LAST);
    stop_ok  = (rx_state == STOP) && rx_mid && rx_s2;
    stop_bad = (rx_state == STOP) && rx_mid && !rx_s2;
  end

  // RX bit timer restarts at every sample point, so data samples stay mid-bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_shf <= '0;
    end else if (rx_state == IDLE) begin
      rx_cnt <= '0;
      rx_idx <= '0;
    end else begin
      rx_cnt <= rx_mid ? '0 : rx_cnt + 1'b1;
      if (rx_state == DATA && rx_mid) begin
        rx_shf <= {rx_s2, rx_shf[7:1]};
        rx_idx <= rx_idx + 1'b1;
      end
    end
  end

  // Read port: deliver good bytes, flag overrun and framing errors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cd      <= '0;
      crda    <= 1'b0;
      rx_ovr  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_ferr <= stop_bad;
      if (stop_ok) begin
        // A cack in the same cycle frees the holding register for the new byte
        if (!crda || cack) begin
          cd   <= rx_shf;
          crda <= 1'b1;
        end else begin
          rx_ovr <= 1'b1;
        end
      end else if (cack) begin
        crda <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ext_uart.sv
// tb_ext_uart: directed bench for the ext_uart bridge at four clocks per bit.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: writes are issued only when idle except where overlap is the point.
module tb_ext_uart;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       txd;
  logic [7:0] cd;
  logic       crda;
  logic       cack = 1'b0;
  logic [7:0] cq = 8'h00;
  logic       cwre = 1'b0;
  logic       cbsy;
  logic       rx_ovr;
  logic       rx_ferr;

  int tests = 0;
  int fails = 0;

  ext_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .txd(txd), .cd(cd), .crda(crda),
    .cack(cack), .cq(cq), .cwre(cwre), .cbsy(cbsy), .rx_ovr(rx_ovr),
    .rx_ferr(rx_ferr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write one byte, then check every txd bit cycle and cbsy across the frame.
  // Optionally fires a second write at cycle inj_at of the frame.
  task automatic tx_frame(input logic [7:0] b, input int inj_at, input logic [7:0] inj);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    cq = b;
    cwre = 1'b1;
    tick;
    cwre = 1'b0;
    for (int i = 0; i < 10 * CPB; i++) begin
      chk("tx_txd", txd, frame[i / CPB]);
      chk("tx_cbsy", cbsy, 1);
      if (i == inj_at) begin
        cq = inj;
        cwre = 1'b1;
      end
      tick;
      cwre = 1'b0;
    end
    chk("tx_end_cbsy", cbsy, 0);
    chk("tx_end_txd", txd, 1);
    for (int i = 0; i < 2 * CPB; i++) begin
      tick;
      chk("tx_idle_txd", txd, 1);
      chk("tx_idle_cbsy", cbsy, 0);
    end
  endtask

  // Drive one serial frame; stop sample lands on the next rising edge after return.
  task automatic rx_frame(input logic [7:0] b, input logic sb);
    logic [9:0] frame;
    frame = {sb, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = frame[k];
      repeat (CPB) tick;
    end
    rxd = 1'b1;
  endtask

  initial begin
    int ferr_seen;
    int crda_seen;
    // Reset state
    repeat (3) tick;
    chk("rst_txd", txd, 1);
    chk("rst_cbsy", cbsy, 0);
    chk("rst_cd", cd, 0);
    chk("rst_crda", crda, 0);
    chk("rst_ovr", rx_ovr, 0);
    chk("rst_ferr", rx_ferr, 0);
    reset = 1'b1;
    tick;

    // Plain frame 0x42
    tx_frame(8'h42, -1, 8'h00);
    // Write while busy is ignored
    tx_frame(8'h55, 12, 8'hFF);
    // Write on the cycle cbsy falls is ignored
    tx_frame(8'hA5, 10 * CPB - 1, 8'h11);

    // Asynchronous reset mid-frame
    cq = 8'h99;
    cwre = 1'b1;
    tick;
    cwre = 1'b0;
    repeat (10) tick;
    chk("midtx_txd_pre", txd, 0);
    #1 reset = 1'b0;
    #1;
    chk("midtx_txd", txd, 1);
    chk("midtx_cbsy", cbsy, 0);
    #2 reset = 1'b1;
    tick;
    tx_frame(8'h3C, -1, 8'h00);

    // Receive 0xA7 and acknowledge it
    rx_frame(8'hA7, 1'b1);
    chk("rx_crda_early", crda, 0);
    tick;
    chk("rx_crda", crda, 1);
    chk("rx_cd", cd, 8'hA7);
    cack = 1'b1;
    tick;
    cack = 1'b0;
    chk("rx_ack_crda", crda, 0);
    chk("rx_ack_cd", cd, 8'hA7);
    chk("rx_ovr0", rx_ovr, 0);
    chk("rx_ferr0", rx_ferr, 0);
    // cack with nothing held does nothing
    cack = 1'b1;
    tick;
    cack = 1'b0;
    chk("rx_idle_ack", crda, 0);

    // Back-to-back frames without acknowledge: second byte lost
    rx_frame(8'h01, 1'b1);
    rx_frame(8'h02, 1'b1);
    tick;
    chk("ovr_cd", cd, 8'h01);
    chk("ovr_crda", crda, 1);
    chk("ovr_flag", rx_ovr, 1);
    repeat (5) tick;
    chk("ovr_sticky", rx_ovr, 1);

    reset = 1'b0;
    tick;
    chk("rst2_ovr", rx_ovr, 0);
    chk("rst2_crda", crda, 0);
    reset = 1'b1;
    tick;

    // Back-to-back with acknowledge on the completing cycle
    rx_frame(8'h01, 1'b1);
    rx_frame(8'h02, 1'b1);
    cack = 1'b1;
    tick;
    cack = 1'b0;
    chk("ackov_cd", cd, 8'h02);
    chk("ackov_crda", crda, 1);
    chk("ackov_ovr", rx_ovr, 0);
    cack = 1'b1;
    tick;
    cack = 1'b0;
    chk("ackov_clr", crda, 0);

    // Framing error: stop bit low
    rx_frame(8'h5A, 1'b0);
    chk("ferr_pre", rx_ferr, 0);
    tick;
    chk("ferr_pulse", rx_ferr, 1);
    chk("ferr_crda", crda, 0);
    tick;
    chk("ferr_single", rx_ferr, 0);
    chk("ferr_cd", cd, 8'h02);

    // One-cycle glitch produces nothing
    repeat (10) tick;
    rxd = 1'b0;
    tick;
    rxd = 1'b1;
    ferr_seen = 0;
    crda_seen = 0;
    for (int i = 0; i < 15 * CPB; i++) begin
      tick;
      if (rx_ferr) ferr_seen++;
      if (crda) crda_seen++;
    end
    chk("glitch_ferr", ferr_seen, 0);
    chk("glitch_crda", crda_seen, 0);
    chk("glitch_ovr", rx_ovr, 0);

    // Receiver still works after the glitch
    rx_frame(8'hC3, 1'b1);
    tick;
    chk("post_glitch_cd", cd, 8'hC3);
    chk("post_glitch_crda", crda, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
